instr_sequencer: RTL



---
 rtl/instr_sequencer_pkg.sv | 40 ++++
 rtl/instr_sequencer_alu.sv | 72 +++++++
 rtl/instr_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, instruction
// field positions, sequencer states and opcode classification helpers.
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LUI  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Low bit of each instruction field; widths are 4/4/4/4/16.
  localparam int OPC_LO  = 28;
  localparam int DST_LO  = 24;
  localparam int SRC1_LO = 20;
  localparam int SRC2_LO = 16;
  localparam int IMM_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_RETIRE = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_t;

  function automatic logic is_alu_op(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_MOV);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] opc);
    return (opc > OP_MOV) && (opc != OP_HALT);
  endfunction

endpackage

// File: rtl/instr_sequencer_alu.sv
// Combinational ALU for the sequencer; reports which flags the opcode updates.
module seq_alu
  import proc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [15:0]   imm16,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero_valid,
  output logic          carry_valid
);

  logic [DW:0]   wide;
  logic [DW-1:0] imm_sext;

  assign imm_sext = {{(DW-16){imm16[15]}}, imm16};

  always_comb begin
    wide        = '0;
    result      = '0;
    carry       = 1'b0;
    zero_valid  = 1'b0;
    carry_valid = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        wide        = {1'b0, a} + {1'b0, b};
        result      = wide[DW-1:0];
        carry       = wide[DW];
        zero_valid  = 1'b1;
        carry_valid = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (a < b).
        wide        = {1'b0, a} - {1'b0, b};
        result      = wide[DW-1:0];
        carry       = wide[DW];
        zero_valid  = 1'b1;
        carry_valid = 1'b1;
      end
      OP_AND: begin
        result      = a & b;
        zero_valid  = 1'b1;
        carry_valid = 1'b1;
      end
      OP_OR: begin
        result      = a | b;
        zero_valid  = 1'b1;
        carry_valid = 1'b1;
      end
      OP_XOR: begin
        result      = a ^ b;
        zero_valid  = 1'b1;
        carry_valid = 1'b1;
      end
      OP_ADDI: begin
        wide        = {1'b0, a} + {1'b0, imm_sext};
        result      = wide[DW-1:0];
        carry       = wide[DW];
        zero_valid  = 1'b1;
        carry_valid = 1'b1;
      end
      OP_LUI:  result = {imm16, {(DW-16){1'b0}}};
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle issue stage: accepts an instruction, reads the register file,
// executes in seq_alu and writes the result back before accepting the next.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NREG_W = 4
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              rf_en,
  output logic              rf_rd,
  output logic              rf_wt,
  output logic [NREG_W-1:0] rf_so1,
  output logic [NREG_W-1:0] rf_so2,
  output logic [NREG_W-1:0] rf_si,
  output logic [DW-1:0]     rf_ip,
  input  logic [DW-1:0]     rf_op1,
  input  logic [DW-1:0]     rf_op2,
  output logic              flag_z,
  output logic              flag_c,
  output logic              retired,
  output logic              illegal,
  output logic              halted
);

  seq_state_t    state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [DW-1:0] result_q, result_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;

  logic [3:0]    opc;
  logic [DW-1:0] alu_result;
  logic          alu_carry, alu_zero_valid, alu_carry_valid;

  assign opc = instr_q[OPC_LO +: 4];

  seq_alu #(.DW(DW)) u_alu (
    .opcode      (opc),
    .a           (rf_op1),
    .b           (rf_op2),
    .imm16       (instr_q[IMM_LO +: 16]),
    .result      (alu_result),
    .carry       (alu_carry),
    .zero_valid  (alu_zero_valid),
    .carry_valid (alu_carry_valid)
  );

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          if (instr[OPC_LO +: 4] == OP_HALT)     state_d = ST_HALTED;
          else if (is_alu_op(instr[OPC_LO +: 4])) state_d = ST_READ;
          else                                   state_d = ST_RETIRE;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        // Register-file data is valid this cycle; LUI/MOV keep the old flags.
        result_d = alu_result;
        if (alu_zero_valid)  flag_z_d = (alu_result == '0);
        if (alu_carry_valid) flag_c_d = alu_carry;
        state_d = ST_WB;
      end
      ST_WB:     state_d = ST_IDLE;
      ST_RETIRE: state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    rf_en       = 1'b0;
    rf_rd       = 1'b0;
    rf_wt       = 1'b0;
    rf_so1      = '0;
    rf_so2      = '0;
    rf_si       = '0;
    rf_ip       = '0;
    retired     = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      ST_IDLE: instr_ready = 1'b1;
      ST_READ: begin
        rf_en  = 1'b1;
        rf_rd  = 1'b1;
        rf_so1 = instr_q[SRC1_LO +: NREG_W];
        rf_so2 = instr_q[SRC2_LO +: NREG_W];
      end
      ST_WB: begin
        rf_en   = 1'b1;
        rf_wt   = 1'b1;
        rf_si   = instr_q[DST_LO +: NREG_W];
        rf_ip   = result_q;
        retired = 1'b1;
      end
      ST_RETIRE: begin
        retired = 1'b1;
        illegal = is_illegal_op(opc);
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule
